// File: rtl/led_water_monitor.sv
// Receive-side checker for a running-light LED bus: locks onto a single lit LED
// rotating every STEP_CYCLES clocks and flags stuck, early, skipped or multi-hot patterns.
module led_water_monitor #(
    parameter int WIDTH       = 8,
    parameter int STEP_CYCLES = 4,
    parameter int LOCK_STEPS  = 3,
    parameter int DIR         = 0,
    localparam int PW         = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] led_in,
    input  logic             clear,
    output logic             locked,
    output logic             fault,
    output logic             err_pulse,
    output logic [7:0]       err_count,
    output logic [15:0]      step_count,
    output logic [PW-1:0]    pos,
    output logic [1:0]       state_dbg
);

    localparam int DW = $clog2(STEP_CYCLES + 1);
    localparam int GW = $clog2(LOCK_STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2,
        S_FAULT   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] led_q;
    logic [WIDTH-1:0] led_next;
    logic [DW-1:0]    dwell_q;
    logic [GW-1:0]    good_q;
    logic [PW-1:0]    enc;
    logic             in_onehot;
    logic             checking;
    logic             is_hold;
    logic             is_step;
    logic             is_err;
    logic             capture;

    // Pattern classification of the current sample against the last accepted value.
    always_comb begin
        enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (led_in[i]) enc = PW'(i);
        end
        in_onehot = (led_in != '0) && ((led_in & (led_in - WIDTH'(1))) == '0);
        if (DIR == 0) led_next = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
        else          led_next = {led_q[0], led_q[WIDTH-1:1]};
        checking = (state_q == S_ACQUIRE) || (state_q == S_LOCKED);
        is_hold  = (led_in == led_q) && (dwell_q < DW'(STEP_CYCLES));
        is_step  = (led_in == led_next) && (dwell_q == DW'(STEP_CYCLES));
        is_err   = checking && !is_hold && !is_step;
        capture  = (state_q == S_IDLE) && in_onehot;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (in_onehot) state_d = S_ACQUIRE;
            S_ACQUIRE: begin
                if (is_err) state_d = S_IDLE;
                else if (is_step && good_q == GW'(LOCK_STEPS - 1)) state_d = S_LOCKED;
            end
            S_LOCKED:  if (is_err) state_d = S_FAULT;
            S_FAULT:   if (clear) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath: accepted value, dwell/lock counters and the visible position.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            led_q      <= '0;
            dwell_q    <= '0;
            good_q     <= '0;
            pos        <= '0;
            step_count <= '0;
        end else if (capture) begin
            led_q   <= led_in;
            dwell_q <= DW'(1);
            good_q  <= '0;
            pos     <= enc;
        end else if (checking && is_hold) begin
            dwell_q <= dwell_q + DW'(1);
        end else if (checking && is_step) begin
            led_q   <= led_in;
            dwell_q <= DW'(1);
            pos     <= enc;
            if (state_q == S_ACQUIRE) good_q <= good_q + GW'(1);
            if (state_q == S_LOCKED)  step_count <= step_count + 16'd1;
        end
    end

    // Clear outranks a simultaneous error: the count ends at zero.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            err_count <= 8'd0;
        end else begin
            err_pulse <= is_err;
            if (clear)                             err_count <= 8'd0;
            else if (is_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    assign locked    = (state_q == S_LOCKED);
    assign fault     = (state_q == S_FAULT);
    assign state_dbg = state_q;

endmodule
